// File: rtl/button_conditioner_pkg.sv
// ============================================================================
// button_conditioner_pkg : channel FSM state codes and default timing values.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package button_conditioner_pkg;

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // 1 ms debounce, 0.5 s first repeat, 0.2 s repeat period at 50 MHz
  localparam int DEF_N_CH          = 4;
  localparam int DEF_DEBOUNCE_CYC  = 50000;
  localparam int DEF_REPEAT_DELAY  = 25000000;
  localparam int DEF_REPEAT_PERIOD = 10000000;
  localparam int DEF_CNT_W         = 26;

  function automatic longint max3(input longint a, input longint b, input longint c);
    longint m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// debounce_channel : synchroniser, debounce FSM and level/pulse/toggle outputs
// for one input. Auto-repeat is built when BUTTON_CONDITIONER_REPEAT_EN is set.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic toggle
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  if ((64'd1 << CNT_W) <= max3(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the configured cycle counts");
  end

  logic             sync_meta;
  logic             sync;
  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             repeat_fire;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      sync      <= sync_meta;
    end
  end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  logic [CNT_W-1:0] rep_count;
  logic             rep_started;

  // The first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
  assign repeat_fire = (state == HELD) && sync &&
                       (rep_started ? (rep_count == CNT_W'(REPEAT_PERIOD - 1))
                                    : (rep_count == CNT_W'(REPEAT_DELAY - 1)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_count   <= '0;
      rep_started <= 1'b0;
    end else if (state != HELD || !sync) begin
      rep_count   <= '0;
      rep_started <= 1'b0;
    end else if (repeat_fire) begin
      rep_count   <= '0;
      rep_started <= 1'b1;
    end else begin
      rep_count   <= rep_count + CNT_W'(1);
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      press         <= repeat_fire;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= PRESS_WAIT;
            count <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state <= IDLE;
            count <= '0;
          end else if (count == DEB_LAST) begin
            state  <= HELD;
            level  <= 1'b1;
            press  <= 1'b1;
            toggle <= ~toggle;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        HELD: begin
          if (!sync) begin
            state <= RELEASE_WAIT;
            count <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync) begin
            state <= HELD;
          end else if (count == DEB_LAST) begin
            state         <= IDLE;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner : N_CH independent debounced button channels.
// Optional auto-repeat via macro BUTTON_CONDITIONER_REPEAT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  // "release" is a reserved word, hence the suffix
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] toggle
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
    ) u_channel (
      .clock        (clock),
      .reset        (reset),
      .btn_in       (btn_in[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .toggle       (toggle[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// tb_button_conditioner : directed stimulus, run-length reference model and
// hand-computed checkpoints for button_conditioner.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_button_conditioner;

  localparam int N_CH = 4;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int CW   = 8;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N_CH-1:0] btn_in = '0;
  logic [N_CH-1:0] level, press, release_pulse, toggle;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  button_conditioner #(
    .N_CH(N_CH), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .btn_in(btn_in),
    .level(level), .press(press), .release_pulse(release_pulse), .toggle(toggle)
  );

  // Reference: the FSM sees the raw input two edges late; a new level is
  // accepted once DEB+1 consecutive samples disagree with the current one.
  logic [N_CH-1:0] m_level = '0, m_press = '0, m_rel = '0, m_tog = '0;
  logic [N_CH-1:0] d1 = '0, d2 = '0;
  int run [N_CH];
  int nh  [N_CH];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_level <= '0; m_press <= '0; m_rel <= '0; m_tog <= '0;
      d1 <= '0; d2 <= '0;
      for (int c = 0; c < N_CH; c++) begin
        run[c] <= 0;
        nh[c]  <= 0;
      end
    end else begin
      d1 <= btn_in;
      d2 <= d1;
      for (int c = 0; c < N_CH; c++) begin
        logic s, l, t, p, q;
        int r, n;
        s = d2[c]; l = m_level[c]; t = m_tog[c]; r = run[c]; n = nh[c];
        p = 1'b0; q = 1'b0;
        if (s != l) begin
          r = r + 1;
          if (r == DEB + 1) begin
            l = s; r = 0;
            if (s) begin p = 1'b1; t = ~t; n = 0; end
            else q = 1'b1;
          end
        end else begin
          if (l && r == 0) begin
            n = n + 1;
            if (REP_EN && (n == RD || (n > RD && (n - RD) % RP == 0))) p = 1'b1;
          end else begin
            n = 0;
          end
          r = 0;
        end
        m_level[c] <= l; m_tog[c] <= t; m_press[c] <= p; m_rel[c] <= q;
        run[c] <= r; nh[c] <= n;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge and compare every output against the model
  task automatic tick();
    @(posedge clock);
    #1;
    check("model_level",   32'(level),         32'(m_level));
    check("model_press",   32'(press),         32'(m_press));
    check("model_release", 32'(release_pulse), 32'(m_rel));
    check("model_toggle",  32'(toggle),        32'(m_tog));
    check("press_release_exclusive", 32'(press & release_pulse), 32'd0);
  endtask

  initial begin
    int cnt, first;
    repeat (3) tick();
    check("reset_outputs", {level, press, release_pulse, toggle}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // Clean press on channel 0: accepted at edge 6
    btn_in[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      check("clean_press_pulse", 32'(press[0]), 32'(k == 6));
      check("clean_press_level", 32'(level[0]), 32'(k == 6));
    end
    check("clean_press_toggle", 32'(toggle[0]), 32'd1);
    check("clean_press_no_release", 32'(release_pulse[0]), 32'd0);

    // Held: repeat pulses at HELD cycles 10,13,16,19 only when built in
    for (int n = 1; n <= 20; n++) begin
      tick();
      check("repeat_press", 32'(press[0]),
            32'(REP_EN && (n == 10 || n == 13 || n == 16 || n == 19)));
      check("repeat_toggle_kept", 32'(toggle[0]), 32'd1);
    end

    // Release glitch of two cycles is rejected
    btn_in[0] = 1'b0;
    tick(); tick();
    btn_in[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("glitch_level", 32'(level[0]), 32'd1);
      check("glitch_no_release", 32'(release_pulse[0]), 32'd0);
    end
    btn_in[0] = 1'b0;
    repeat (10) tick();
    check("ch0_released", 32'(level[0]), 32'd0);

    // Bounce on channel 1: one press, 6 edges after the final rise
    btn_in[1] = 1'b1;
    repeat (3) tick();
    btn_in[1] = 1'b0;
    tick();
    btn_in[1] = 1'b1;
    cnt = 0; first = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (press[1]) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    check("bounce_press_count", 32'(cnt), 32'd1);
    check("bounce_press_edge", 32'(first), 32'd6);

    // Simultaneous press on channels 2 and 3
    btn_in[3:2] = 2'b11;
    for (int k = 0; k <= 6; k++) begin
      tick();
      check("simultaneous_press", 32'(press[3:2]), (k == 6) ? 32'd3 : 32'd0);
    end
    btn_in[3:2] = 2'b00;
    repeat (10) tick();
    btn_in[2] = 1'b1;
    repeat (10) tick();
    btn_in[2] = 1'b0;
    repeat (10) tick();
    check("toggle_ch2_back", 32'(toggle[2]), 32'd0);
    check("toggle_ch3_set", 32'(toggle[3]), 32'd1);

    // Reset two cycles into PRESS_WAIT; channel 1 still held high
    btn_in[0] = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("reset_mid_outputs", {level, press, release_pulse, toggle}, 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      check("post_reset_press", 32'(press), (k == 6) ? 32'h3 : 32'h0);
    end

    btn_in = '0;
    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
